systolic_feed_sequencer: RTL and testbench

Control FSM that streams a tile of input rows from the activation buffer into the Systolic_Data_Setup skew stage in front of the systolic array. It clears the skew shift registers, accepts NUM_ROWS rows through a valid/ready handshake, then drains the skew with zero rows so every lane's last element reaches the array. It drives the skew stage's EN and SYNC_RST and selects zero injection on its inputs. It honours downstream back-pressure and reports completion.

---
 rtl/systolic_feed_sequencer.sv | 120 ++++++++++++
 tb/tb_systolic_feed_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_sequencer.sv
// Tile sequencer for the skew stage: clear, feed NUM_ROWS rows, drain with zero rows, pulse DONE.
// Handshake is combinational (zero latency); STALL freezes SETUP_EN and IN_READY in FEED/DRAIN.
module systolic_feed_sequencer #(
    parameter int SA_LENGTH     = 256,
    parameter int ROW_CNT_WIDTH = 16,
    parameter int DRAIN_EXTRA   = 0
) (
    input  logic                     CLK,
    input  logic                     ASYNC_RST,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic [ROW_CNT_WIDTH-1:0] NUM_ROWS,
    input  logic                     STALL,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    output logic                     SETUP_EN,
    output logic                     SETUP_SYNC_RST,
    output logic                     ZERO_IN,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [ROW_CNT_WIDTH-1:0] ROWS_ACCEPTED
);

    localparam int DCW = $clog2(SA_LENGTH + DRAIN_EXTRA) + 1;
    localparam logic [DCW-1:0] DRAIN_LEN = DCW'(SA_LENGTH - 1 + DRAIN_EXTRA);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [ROW_CNT_WIDTH-1:0] num_rows_q, num_rows_d;
    logic [ROW_CNT_WIDTH-1:0] rows_acc_q, rows_acc_d;
    logic [DCW-1:0]           drain_cnt_q, drain_cnt_d;

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q     <= IDLE;
            num_rows_q  <= '0;
            rows_acc_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            num_rows_q  <= num_rows_d;
            rows_acc_q  <= rows_acc_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        num_rows_d     = num_rows_q;
        rows_acc_d     = rows_acc_q;
        drain_cnt_d    = drain_cnt_q;
        IN_READY       = 1'b0;
        SETUP_EN       = 1'b0;
        BUSY           = (state_q != IDLE);
        DONE           = (state_q == FINISH);
        ZERO_IN        = (state_q == DRAIN);
        SETUP_SYNC_RST = (state_q == CLEAR) || (BUSY && ABORT);

        case (state_q)
            IDLE: begin
                if (START) begin
                    num_rows_d  = NUM_ROWS;
                    rows_acc_d  = '0;
                    drain_cnt_d = '0;
                    state_d     = CLEAR;
                end
            end
            CLEAR: begin
                state_d = (num_rows_q != '0) ? FEED : FINISH;
            end
            FEED: begin
                IN_READY = !STALL;
                SETUP_EN = IN_VALID && !STALL;
                if (SETUP_EN) begin
                    if (rows_acc_q < num_rows_q) begin
                        rows_acc_d = rows_acc_q + ROW_CNT_WIDTH'(1);
                    end
                    // Last row: skip DRAIN entirely when there is nothing to flush.
                    if (rows_acc_q + ROW_CNT_WIDTH'(1) == num_rows_q) begin
                        state_d = (DRAIN_LEN == '0) ? FINISH : DRAIN;
                    end
                end
            end
            DRAIN: begin
                SETUP_EN = !STALL;
                if (SETUP_EN) begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                    if (drain_cnt_d == DRAIN_LEN) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything; no row is consumed in the abort cycle.
        if (BUSY && ABORT) begin
            state_d     = IDLE;
            IN_READY    = 1'b0;
            SETUP_EN    = 1'b0;
            rows_acc_d  = rows_acc_q;
            drain_cnt_d = drain_cnt_q;
        end
    end

    assign ROWS_ACCEPTED = rows_acc_q;

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Directed bench for systolic_feed_sequencer with SA_LENGTH=4; per-cycle expected output tables.
module tb_systolic_feed_sequencer;

    logic        CLK = 1'b0;
    logic        ASYNC_RST;
    logic        START;
    logic        ABORT;
    logic [15:0] NUM_ROWS;
    logic        STALL;
    logic        IN_VALID;
    logic        IN_READY;
    logic        SETUP_EN;
    logic        SETUP_SYNC_RST;
    logic        ZERO_IN;
    logic        BUSY;
    logic        DONE;
    logic [15:0] ROWS_ACCEPTED;

    int checks   = 0;
    int failures = 0;
    int en_cnt   = 0;

    // Per-cycle tables: expected {IN_READY,SETUP_EN,SETUP_SYNC_RST,ZERO_IN,BUSY,DONE}.
    logic [0:15][5:0]  exp_p;
    logic [0:15]       st_p, vld_p, stl_p, ab_p, rows_chk;
    logic [0:15][15:0] rows_p;

    systolic_feed_sequencer #(
        .SA_LENGTH    (4),
        .ROW_CNT_WIDTH(16),
        .DRAIN_EXTRA  (0)
    ) dut (
        .CLK           (CLK),
        .ASYNC_RST     (ASYNC_RST),
        .START         (START),
        .ABORT         (ABORT),
        .NUM_ROWS      (NUM_ROWS),
        .STALL         (STALL),
        .IN_VALID      (IN_VALID),
        .IN_READY      (IN_READY),
        .SETUP_EN      (SETUP_EN),
        .SETUP_SYNC_RST(SETUP_SYNC_RST),
        .ZERO_IN       (ZERO_IN),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ROWS_ACCEPTED (ROWS_ACCEPTED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr_tables();
        exp_p    = '0;
        st_p     = '0;
        vld_p    = '1;
        stl_p    = '0;
        ab_p     = '0;
        rows_chk = '0;
        rows_p   = '0;
        en_cnt   = 0;
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic run(input int n, input string tag);
        logic [5:0] obs, msk;
        for (int i = 0; i < n; i++) begin
            START    = st_p[i];
            IN_VALID = vld_p[i];
            STALL    = stl_p[i];
            ABORT    = ab_p[i];
            @(negedge CLK);
            obs = {IN_READY, SETUP_EN, SETUP_SYNC_RST, ZERO_IN, BUSY, DONE};
            msk = ab_p[i] ? 6'b011111 : 6'b111111;
            chk($sformatf("%s_c%0d_outs", tag, i), {26'd0, obs & msk}, {26'd0, exp_p[i] & msk});
            if (rows_chk[i]) begin
                chk($sformatf("%s_c%0d_rows", tag, i), {16'd0, ROWS_ACCEPTED}, {16'd0, rows_p[i]});
            end
            if (SETUP_EN) en_cnt++;
            @(posedge CLK);
            #1;
        end
        START = 1'b0;
        ABORT = 1'b0;
    endtask

    task automatic load_nominal();
        clr_tables();
        st_p        = 16'b1000_0000_0000_0000;
        exp_p[0:9]  = {6'b000000, 6'b001010, 6'b110010, 6'b110010, 6'b110010,
                       6'b010110, 6'b010110, 6'b010110, 6'b000011, 6'b000000};
    endtask

    initial begin
        ASYNC_RST = 1'b0;
        START     = 1'b0;
        ABORT     = 1'b0;
        NUM_ROWS  = 16'd3;
        STALL     = 1'b0;
        IN_VALID  = 1'b0;
        #1;
        chk("reset_outs", {26'd0, IN_READY, SETUP_EN, SETUP_SYNC_RST, ZERO_IN, BUSY, DONE}, 32'd0);
        chk("reset_rows", {16'd0, ROWS_ACCEPTED}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        ASYNC_RST = 1'b1;

        // Nominal 3-row tile.
        load_nominal();
        run(10, "nominal");
        chk("nominal_en_pulses", en_cnt, 6);
        chk("nominal_rows", {16'd0, ROWS_ACCEPTED}, 32'd3);

        // IN_VALID gap in cycle 3, STALL in cycle 6.
        clr_tables();
        st_p         = 16'b1000_0000_0000_0000;
        vld_p        = 16'b1110_1111_1111_1111;
        stl_p        = 16'b0000_0010_0000_0000;
        exp_p[0:11]  = {6'b000000, 6'b001010, 6'b110010, 6'b100010, 6'b110010, 6'b110010,
                        6'b000110, 6'b010110, 6'b010110, 6'b010110, 6'b000011, 6'b000000};
        run(12, "gaps");
        chk("gaps_en_pulses", en_cnt, 6);
        chk("gaps_rows", {16'd0, ROWS_ACCEPTED}, 32'd3);

        // Empty tile.
        clr_tables();
        NUM_ROWS    = 16'd0;
        st_p        = 16'b1000_0000_0000_0000;
        exp_p[0:3]  = {6'b000000, 6'b001010, 6'b000011, 6'b000000};
        run(4, "empty");
        chk("empty_en_pulses", en_cnt, 0);
        chk("empty_rows", {16'd0, ROWS_ACCEPTED}, 32'd0);

        // Abort in the second FEED cycle, then a full tile.
        clr_tables();
        NUM_ROWS    = 16'd3;
        st_p        = 16'b1000_0000_0000_0000;
        ab_p        = 16'b0001_0000_0000_0000;
        exp_p[0:4]  = {6'b000000, 6'b001010, 6'b110010, 6'b001010, 6'b000000};
        run(5, "abort");
        load_nominal();
        run(10, "after_abort");
        chk("after_abort_en_pulses", en_cnt, 6);
        chk("after_abort_rows", {16'd0, ROWS_ACCEPTED}, 32'd3);

        // START held through FEED must not restart or clear the count.
        load_nominal();
        st_p         = 16'b1111_1110_0000_0000;
        rows_chk     = 16'b0111_1111_1100_0000;
        rows_p[1:9]  = {16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
        run(10, "start_held");
        chk("start_held_en_pulses", en_cnt, 6);

        // Asynchronous reset in DRAIN.
        load_nominal();
        run(5, "pre_rst");
        #2;
        chk("drain_before_rst", {30'd0, SETUP_EN, ZERO_IN}, 32'd3);
        ASYNC_RST = 1'b0;
        #1;
        chk("async_rst_outs", {26'd0, IN_READY, SETUP_EN, SETUP_SYNC_RST, ZERO_IN, BUSY, DONE}, 32'd0);
        chk("async_rst_rows", {16'd0, ROWS_ACCEPTED}, 32'd0);
        @(posedge CLK);
        #1;
        ASYNC_RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("post_rst_idle", {26'd0, IN_READY, SETUP_EN, SETUP_SYNC_RST, ZERO_IN, BUSY, DONE}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
